interrupt_acknowledge_8259a: RTL and testbench

INTERRUPT_ACKNOWLEDGE_8259A -- requirements
Module: interrupt_acknowledge_8259a

---
 rtl/interrupt_acknowledge_8259a_pkg.sv | 35 +++
 rtl/interrupt_acknowledge_8259a_resolver.sv | 26 ++
 rtl/interrupt_acknowledge_8259a.sv | 167 ++++++++++++++++
 tb/tb_interrupt_acknowledge_8259a.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_acknowledge_8259a_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge logic.
//   - ack_state_e      : acknowledge-sequence FSM states
//   - SpuriousLevel    : level reported when the request vanished before INTA
//   - priority_encode  : fixed-priority (bit 0 highest) encoder, reusable by IRR/ISR blocks
//   - level_onehot     : 3-bit level to 8-bit one-hot mask
package interrupt_acknowledge_8259a_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StAck1,
        StWait2,
        StAck2
    } ack_state_e;

    localparam logic [2:0] SpuriousLevel = 3'd7;

    // Returns {found, level}; level is the lowest set bit index (IR0 has top priority).
    function automatic logic [3:0] priority_encode(input logic [7:0] vec);
        logic [3:0] result;
        result = 4'b0000;
        // Scan downwards so the lowest set index is the one that sticks.
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                result = {1'b1, 3'(i)};
            end
        end
        return result;
    endfunction

    function automatic logic [7:0] level_onehot(input logic [2:0] level);
        return 8'h01 << level;
    endfunction

endpackage

// File: rtl/interrupt_acknowledge_8259a_resolver.sv
// priority_resolver_8259a: combinational fixed-priority arbiter.
// Ports:
//   i_pending     [7:0] unmasked pending requests (IRR & ~mask)
//   i_in_service  [7:0] current ISR contents
//   o_qualified         a pending level beats everything currently in service
//   o_level       [2:0] highest-priority pending level (valid when o_qualified)
module priority_resolver_8259a
    import interrupt_acknowledge_8259a_pkg::*;
(
    input  logic [7:0] i_pending,
    input  logic [7:0] i_in_service,
    output logic       o_qualified,
    output logic [2:0] o_level
);

    logic [3:0] w_req;
    logic [3:0] w_isr;

    assign w_req = priority_encode(i_pending);
    assign w_isr = priority_encode(i_in_service);

    assign o_level = w_req[2:0];
    // Strictly higher priority means a strictly lower index than the top ISR bit.
    assign o_qualified = w_req[3] && (!w_isr[3] || (w_req[2:0] < w_isr[2:0]));

endmodule

// File: rtl/interrupt_acknowledge_8259a.sv
// interrupt_acknowledge_8259a: 8259A INT/INTA handshake, ISR maintenance and vector output.
// Ports:
//   clock, reset_n                single clock, synchronous active-low reset
//   interrupt_request_register    IRR contents (bit 0 = IR0)
//   interrupt_mask                1 = level masked
//   interrupt_acknowledge_n       CPU INTA, active-low, synchronous
//   auto_eoi_config               1 = clear ISR bit at end of second INTA
//   end_of_interrupt              one-cycle non-specific EOI
//   interrupt_vector_base         vector bits T7..T3
//   interrupt_to_cpu              INT to CPU
//   freeze                        IRR freeze strobe
//   clear_interrupt_request       one-hot, one-cycle IRR clear
//   in_service_register           ISR contents
//   data_bus_out, data_bus_enable vector byte and its enable
module interrupt_acknowledge_8259a
    import interrupt_acknowledge_8259a_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge_n,
    input  logic       auto_eoi_config,
    input  logic       end_of_interrupt,
    input  logic [4:0] interrupt_vector_base,
    output logic       interrupt_to_cpu,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [7:0] data_bus_out,
    output logic       data_bus_enable
);

    ack_state_e r_state;
    ack_state_e w_state_next;

    logic       r_inta_prev;
    logic       r_int;
    logic       r_freeze;
    logic [7:0] r_clear;
    logic [7:0] r_isr;
    logic [7:0] r_dbo;
    logic       r_dbe;
    logic [2:0] r_level;
    logic       r_spurious;

    logic [7:0] w_pending;
    logic       w_qualified;
    logic [2:0] w_sel_level;
    logic       w_inta_fall;
    logic       w_inta_rise;
    logic [3:0] w_isr_top;
    logic [7:0] w_eoi_clear;
    logic [7:0] w_aeoi_clear;
    logic [7:0] w_set_mask;
    logic [7:0] w_isr_next;
    logic [2:0] w_level_next;
    logic       w_spurious_next;
    logic [7:0] w_dbo_next;

    assign w_pending   = interrupt_request_register & ~interrupt_mask;
    assign w_inta_fall = r_inta_prev && !interrupt_acknowledge_n;
    assign w_inta_rise = !r_inta_prev && interrupt_acknowledge_n;

    priority_resolver_8259a u_resolver (
        .i_pending    (w_pending),
        .i_in_service (r_isr),
        .o_qualified  (w_qualified),
        .o_level      (w_sel_level)
    );

    // Non-specific EOI always acts on the ISR as it stands before this edge.
    assign w_isr_top   = priority_encode(r_isr);
    assign w_eoi_clear = (end_of_interrupt && w_isr_top[3]) ? level_onehot(w_isr_top[2:0])
                                                            : 8'h00;

    always_comb begin
        w_state_next    = r_state;
        w_level_next    = r_level;
        w_spurious_next = r_spurious;
        w_set_mask      = 8'h00;
        w_aeoi_clear    = 8'h00;

        unique case (r_state)
            StIdle: begin
                if (w_qualified) begin
                    w_state_next = StRequest;
                end
            end
            StRequest: begin
                if (w_inta_fall) begin
                    w_state_next = StAck1;
                    if (w_qualified) begin
                        w_level_next    = w_sel_level;
                        w_spurious_next = 1'b0;
                        w_set_mask      = level_onehot(w_sel_level);
                    end else begin
                        // Request withdrawn after INT was raised: answer with IR7, touch nothing.
                        w_level_next    = SpuriousLevel;
                        w_spurious_next = 1'b1;
                    end
                end
            end
            StAck1: begin
                if (w_inta_rise) begin
                    w_state_next = StWait2;
                end
            end
            StWait2: begin
                if (w_inta_fall) begin
                    w_state_next = StAck2;
                end
            end
            StAck2: begin
                if (w_inta_rise) begin
                    w_state_next = StIdle;
                    if (auto_eoi_config && !r_spurious) begin
                        w_aeoi_clear = level_onehot(r_level);
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        w_isr_next = (r_isr & ~w_eoi_clear & ~w_aeoi_clear) | w_set_mask;
        // Vector is driven for every ACK2 cycle and held otherwise.
        w_dbo_next = (w_state_next == StAck2) ? {interrupt_vector_base, w_level_next} : r_dbo;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_inta_prev <= 1'b1;
            r_int       <= 1'b0;
            r_freeze    <= 1'b0;
            r_clear     <= 8'h00;
            r_isr       <= 8'h00;
            r_dbo       <= 8'h00;
            r_dbe       <= 1'b0;
            r_level     <= 3'd0;
            r_spurious  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_inta_prev <= interrupt_acknowledge_n;
            // Outputs are registered from the next state so they line up with it.
            r_int       <= (w_state_next == StRequest);
            r_freeze    <= (w_state_next == StAck1) || (w_state_next == StWait2) ||
                           (w_state_next == StAck2);
            r_clear     <= w_set_mask;
            r_isr       <= w_isr_next;
            r_dbo       <= w_dbo_next;
            r_dbe       <= (w_state_next == StAck2);
            r_level     <= w_level_next;
            r_spurious  <= w_spurious_next;
        end
    end

    assign interrupt_to_cpu        = r_int;
    assign freeze                  = r_freeze;
    assign clear_interrupt_request = r_clear;
    assign in_service_register     = r_isr;
    assign data_bus_out            = r_dbo;
    assign data_bus_enable         = r_dbe;

endmodule

// File: tb/tb_interrupt_acknowledge_8259a.sv
// Self-checking bench for interrupt_acknowledge_8259a: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_interrupt_acknowledge_8259a;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic [7:0] irr;
    logic [7:0] mask;
    logic       inta_n;
    logic       aeoi;
    logic       eoi;
    logic [4:0] base;
    logic       int_cpu;
    logic       frz;
    logic [7:0] clr;
    logic [7:0] isr;
    logic [7:0] dbo;
    logic       dbe;

    interrupt_acknowledge_8259a dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .interrupt_request_register (irr),
        .interrupt_mask             (mask),
        .interrupt_acknowledge_n    (inta_n),
        .auto_eoi_config            (aeoi),
        .end_of_interrupt           (eoi),
        .interrupt_vector_base      (base),
        .interrupt_to_cpu           (int_cpu),
        .freeze                     (frz),
        .clear_interrupt_request    (clr),
        .in_service_register        (isr),
        .data_bus_out               (dbo),
        .data_bus_enable            (dbe)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a request, 1 INT raised, 2 first INTA low,
    //        3 between INTA pulses, 4 vector on the bus
    int         m_phase;
    logic       m_valid = 1'b0;
    logic       m_prev;
    logic [7:0] m_isr, m_clr, m_dbo;
    logic       m_int, m_frz, m_dbe;
    logic [2:0] m_lvl;
    logic       m_spur;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    always @(posedge clock) begin
        logic       fall, rise, qual;
        int         win, top;
        logic [7:0] pend, nisr;
        if (!reset_n) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_prev  = 1'b1;
            m_isr   = 8'h00;
            m_clr   = 8'h00;
            m_dbo   = 8'h00;
            m_int   = 1'b0;
            m_frz   = 1'b0;
            m_dbe   = 1'b0;
            m_lvl   = 3'd0;
            m_spur  = 1'b0;
        end else if (m_valid) begin
            fall = m_prev && !inta_n;
            rise = !m_prev && inta_n;
            pend = irr & ~mask;
            win  = lowest(pend);
            top  = lowest(m_isr);
            qual = (win < 8) && (win < top);
            nisr = m_isr;
            if (eoi && top < 8) nisr[top] = 1'b0;
            m_clr = 8'h00;
            case (m_phase)
                0: if (qual) m_phase = 1;
                1: if (fall) begin
                    m_phase = 2;
                    if (qual) begin
                        m_lvl     = 3'(win);
                        m_spur    = 1'b0;
                        nisr[win] = 1'b1;
                        m_clr[win] = 1'b1;
                    end else begin
                        m_lvl  = 3'd7;
                        m_spur = 1'b1;
                    end
                end
                2: if (rise) m_phase = 3;
                3: if (fall) m_phase = 4;
                default: if (rise) begin
                    m_phase = 0;
                    if (aeoi && !m_spur) nisr[m_lvl] = 1'b0;
                end
            endcase
            m_isr = nisr;
            if (m_phase == 4) m_dbo = {base, m_lvl};
            m_int  = (m_phase == 1);
            m_frz  = (m_phase >= 2);
            m_dbe  = (m_phase == 4);
            m_prev = inta_n;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("outputs{int,frz,clr,isr,dbe,dbo}",
                32'({int_cpu, frz, clr, isr, dbe, dbo}),
                32'({m_int, m_frz, m_clr, m_isr, m_dbe, m_dbo}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clock);
    endtask

    // Two full INTA pulses; the IRR bit is dropped when its clear pulse appears.
    task automatic inta_cycle(output logic [7:0] clr_s, output logic [7:0] isr_s,
                              output logic [7:0] vec_s, output logic dbe_s);
        inta_n = 1'b0; step();
        clr_s = clr;
        isr_s = isr;
        irr   = irr & ~clr;
        inta_n = 1'b1; step();
        inta_n = 1'b0; step();
        vec_s = dbo;
        dbe_s = dbe;
        inta_n = 1'b1; step();
    endtask

    logic [7:0] c_s, i_s, v_s;
    logic       e_s;

    initial begin
        reset_n = 1'b0;
        irr     = 8'h00;
        mask    = 8'h00;
        inta_n  = 1'b1;
        aeoi    = 1'b0;
        eoi     = 1'b0;
        base    = 5'h10;
        repeat (3) step();
        chk("reset_isr", 32'(isr), 32'h00);
        chk("reset_int", 32'(int_cpu), 32'h0);
        reset_n = 1'b1;
        step();

        // Single request on IR3
        irr = 8'h08; step();
        chk("ir3_int_rise", 32'(int_cpu), 32'h1);
        inta_n = 1'b0; step();
        chk("ir3_clear", 32'(clr), 32'h08);
        chk("ir3_isr", 32'(isr), 32'h08);
        chk("ir3_freeze", 32'(frz), 32'h1);
        chk("ir3_int_drop", 32'(int_cpu), 32'h0);
        irr = 8'h00; step();
        chk("ir3_clear_one_cycle", 32'(clr), 32'h00);
        inta_n = 1'b1; step();
        inta_n = 1'b0; step();
        chk("ir3_dbe", 32'(dbe), 32'h1);
        chk("ir3_vector", 32'(dbo), 32'h83);
        inta_n = 1'b1; step();
        chk("ir3_dbe_off", 32'(dbe), 32'h0);
        chk("ir3_freeze_off", 32'(frz), 32'h0);
        chk("ir3_isr_kept", 32'(isr), 32'h08);
        chk("ir3_vector_held", 32'(dbo), 32'h83);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("ir3_eoi", 32'(isr), 32'h00);

        // IR1 beats IR3, then lower levels are blocked until EOI
        irr = 8'h0A; step();
        chk("ir1_int", 32'(int_cpu), 32'h1);
        inta_cycle(c_s, i_s, v_s, e_s);
        chk("ir1_clear", 32'(c_s), 32'h02);
        chk("ir1_isr", 32'(i_s), 32'h02);
        chk("ir1_vector", 32'(v_s), 32'h81);
        irr = 8'h20; step(); step();
        chk("blocked_int", 32'(int_cpu), 32'h0);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("eoi_isr", 32'(isr), 32'h00);
        step();
        chk("eoi_int_rise", 32'(int_cpu), 32'h1);
        inta_cycle(c_s, i_s, v_s, e_s);
        chk("ir5_vector", 32'(v_s), 32'h85);
        eoi = 1'b1; step(); eoi = 1'b0;

        // Withdrawn request gives the spurious IR7 vector
        irr = 8'h04; step();
        irr = 8'h00; step();
        chk("spur_int_held", 32'(int_cpu), 32'h1);
        inta_cycle(c_s, i_s, v_s, e_s);
        chk("spur_clear", 32'(c_s), 32'h00);
        chk("spur_isr", 32'(i_s), 32'h00);
        chk("spur_vector", 32'(v_s), 32'h87);
        chk("spur_dbe", 32'(e_s), 32'h1);

        // Auto-EOI
        aeoi = 1'b1;
        irr = 8'h01; step();
        inta_cycle(c_s, i_s, v_s, e_s);
        chk("aeoi_isr_during", 32'(i_s), 32'h01);
        chk("aeoi_vector", 32'(v_s), 32'h80);
        chk("aeoi_isr_after", 32'(isr), 32'h00);
        aeoi = 1'b0;

        // Reset in WAIT2
        irr = 8'h10; step();
        inta_n = 1'b0; step();
        irr = irr & ~clr;
        inta_n = 1'b1; step();
        reset_n = 1'b0; step();
        chk("rst_outputs", 32'({int_cpu, frz, clr, isr, dbe, dbo}), 32'h0);
        reset_n = 1'b1;
        irr = 8'h10; step();
        chk("rst_back_to_idle", 32'(int_cpu), 32'h1);
        reset_n = 1'b0; irr = 8'h00; step();
        reset_n = 1'b1;

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            step();
            irr = irr & ~clr;
            if ($urandom_range(0, 7) == 0) irr = irr | 8'($urandom);
            if ($urandom_range(0, 19) == 0) irr = 8'($urandom);
            if ($urandom_range(0, 29) == 0) mask = ($urandom_range(0, 1) == 1) ? 8'($urandom)
                                                                                : 8'h00;
            if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
            eoi = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) aeoi = ~aeoi;
            if ($urandom_range(0, 39) == 0) base = 5'($urandom);
            reset_n = ($urandom_range(0, 249) != 0);
        end
        reset_n = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
